// File: rtl/riscv_pkg.sv
// Shared core parameters and the boot loader's state encoding.
package riscv_pkg;
  localparam int IM_DEPTH = 64;
  localparam int SM_DEPTH = 64;
  localparam int RF_DEPTH = 32;
  localparam int LDR_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE, IM_CNT, IM_DATA, DM_CNT, DM_DATA, DONE, ERR
  } loader_state_e;
endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid fires on the 4th byte.
module word_assembler
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [23:0] sr;

  // The 4th byte is used straight off the bus so the word is ready on its own handshake edge.
  assign word_valid = byte_valid && (cnt == 2'(LDR_BYTES_PER_WORD - 1));
  assign word       = {byte_data, sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
      sr  <= {byte_data, sr[23:8]};
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: streams count-prefixed IM then DM images into the core and holds it in reset.
module prog_loader
  import riscv_pkg::*;
#(
  parameter  int IM_WORDS = IM_DEPTH,
  parameter  int SM_WORDS = SM_DEPTH,
  localparam int IM_AW    = $clog2(IM_WORDS << 2),
  localparam int SM_AW    = $clog2(SM_WORDS << 2)
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             Memory_Initialization,
  output logic [IM_AW-1:0] writeAddr_IM,
  output logic [31:0]      writeData_IM,
  output logic             writeEn_IM,
  output logic [SM_AW-1:0] writeAddr_SM_TB,
  output logic [31:0]      writeData_SM_TB,
  output logic             writeEn_SM_TB,
  output logic             core_reset,
  output logic             done,
  output logic             err
);
  loader_state_e state;
  logic [31:0]   n_words, word_idx, word;
  logic          acc, word_valid, can_start, last_word;

  assign rx_ready  = state inside {IM_CNT, IM_DATA, DM_CNT, DM_DATA};
  assign acc       = rx_valid && rx_ready;
  assign can_start = start && (state inside {IDLE, DONE, ERR});
  assign last_word = (word_idx == n_words - 32'd1);

  word_assembler u_asm (
    .clk        (clk_100MHz),
    .rst        (reset),
    .clear      (can_start),
    .byte_valid (acc),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      Memory_Initialization <= 1'b0;
      writeAddr_IM          <= '0;
      writeData_IM          <= '0;
      writeEn_IM            <= 1'b0;
      writeAddr_SM_TB       <= '0;
      writeData_SM_TB       <= '0;
      writeEn_SM_TB         <= 1'b0;
      core_reset            <= 1'b1;
      done                  <= 1'b0;
      err                   <= 1'b0;
      n_words               <= '0;
      word_idx              <= '0;
    end else begin
      writeEn_IM    <= 1'b0;
      writeEn_SM_TB <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (can_start) begin
            state                 <= IM_CNT;
            done                  <= 1'b0;
            err                   <= 1'b0;
            core_reset            <= 1'b1;
            Memory_Initialization <= 1'b1;
            word_idx              <= '0;
          end else if (state == DONE) begin
            // Entered from the last data write: release the core one cycle after that strobe.
            done                  <= 1'b1;
            core_reset            <= 1'b0;
            Memory_Initialization <= 1'b0;
          end
        end
        IM_CNT: if (word_valid) begin
          word_idx <= '0;
          n_words  <= word;
          if (word > 32'(IM_WORDS)) begin
            state                 <= ERR;
            err                   <= 1'b1;
            Memory_Initialization <= 1'b0;
          end else if (word == 32'd0) state <= DM_CNT;
          else state <= IM_DATA;
        end
        IM_DATA: if (word_valid) begin
          writeEn_IM   <= 1'b1;
          writeData_IM <= word;
          writeAddr_IM <= IM_AW'(word_idx << 2);
          word_idx     <= last_word ? 32'd0 : word_idx + 32'd1;
          if (last_word) state <= DM_CNT;
        end
        DM_CNT: if (word_valid) begin
          word_idx <= '0;
          n_words  <= word;
          if (word > 32'(SM_WORDS)) begin
            state                 <= ERR;
            err                   <= 1'b1;
            Memory_Initialization <= 1'b0;
          end else if (word == 32'd0) begin
            state                 <= DONE;
            done                  <= 1'b1;
            core_reset            <= 1'b0;
            Memory_Initialization <= 1'b0;
          end else state <= DM_DATA;
        end
        DM_DATA: if (word_valid) begin
          writeEn_SM_TB   <= 1'b1;
          writeData_SM_TB <= word;
          writeAddr_SM_TB <= SM_AW'(word_idx << 2);
          word_idx        <= last_word ? 32'd0 : word_idx + 32'd1;
          if (last_word) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized load streams checked against a queue-based model of the expected memory writes.
module tb_prog_loader;
  localparam int IMW = 16;
  localparam int SMW = 16;
  localparam int IAW = $clog2(IMW << 2);
  localparam int SAW = $clog2(SMW << 2);

  logic           clk = 1'b0;
  logic           rst, start, rx_valid, rx_ready;
  logic [7:0]     rx_data;
  logic           mem_init, we_im, we_sm, core_reset, done, err;
  logic [IAW-1:0] wa_im;
  logic [SAW-1:0] wa_sm;
  logic [31:0]    wd_im, wd_sm;

  prog_loader #(.IM_WORDS(IMW), .SM_WORDS(SMW)) dut (
    .clk_100MHz            (clk),
    .reset                 (rst),
    .start                 (start),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_ready              (rx_ready),
    .Memory_Initialization (mem_init),
    .writeAddr_IM          (wa_im),
    .writeData_IM          (wd_im),
    .writeEn_IM            (we_im),
    .writeAddr_SM_TB       (wa_sm),
    .writeData_SM_TB       (wd_sm),
    .writeEn_SM_TB         (we_sm),
    .core_reset            (core_reset),
    .done                  (done),
    .err                   (err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int bytes_acc = 0, wr_cnt = 0;
  bit prev4 = 1'b0;
  logic [31:0] im_a[$], im_d[$], sm_a[$], sm_d[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Handshake tracker: was the byte taken on this edge the 4th of a word?
  always @(posedge clk) begin
    prev4 <= rx_valid && rx_ready && (bytes_acc % 4 == 3);
    if (rx_valid && rx_ready) bytes_acc <= bytes_acc + 1;
  end

  // Every write strobe must match the head of the expected-write queues.
  always @(negedge clk) begin
    if (we_im || we_sm) begin
      wr_cnt++;
      chk("same_cycle", 32'(we_im & we_sm), 32'd0);
      chk("strobe_after_4th", 32'(prev4), 32'd1);
      chk("meminit_on_write", 32'(mem_init), 32'd1);
    end
    if (we_im) begin
      if (im_a.size() == 0) chk("im_stray", 32'd1, 32'd0);
      else begin
        chk("im_addr", 32'(wa_im), im_a.pop_front());
        chk("im_data", wd_im, im_d.pop_front());
      end
    end
    if (we_sm) begin
      if (sm_a.size() == 0) chk("sm_stray", 32'd1, 32'd0);
      else begin
        chk("sm_addr", 32'(wa_sm), sm_a.pop_front());
        chk("sm_data", wd_sm, sm_d.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd) while ($urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("rx_ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], rnd);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    bytes_acc = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ignored_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_core_reset", 32'(core_reset), 32'd1);
    chk("ignored_start_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic check_err();
    chk("err_flag", 32'(err), 32'd1);
    chk("err_core_reset", 32'(core_reset), 32'd1);
    chk("err_ready", 32'(rx_ready), 32'd0);
    chk("err_meminit", 32'(mem_init), 32'd0);
    chk("err_done", 32'(done), 32'd0);
  endtask

  // One full load; a word index in glitch gets an out-of-state start pulse after it.
  task automatic do_load(input int n_im, input int n_dm, input bit rnd, input int glitch,
                         input logic [31:0] fx[$]);
    logic [31:0] w[$];
    int nw, wr0;
    nw = n_im + ((n_dm <= SMW) ? n_dm : 0);
    for (int i = 0; i < nw; i++) w.push_back((i < fx.size()) ? fx[i] : $urandom);
    if (n_im <= IMW) for (int i = 0; i < n_im; i++) begin
      im_a.push_back(32'(i * 4));
      im_d.push_back(w[i]);
    end
    if (n_im <= IMW && n_dm <= SMW) for (int j = 0; j < n_dm; j++) begin
      sm_a.push_back(32'(j * 4));
      sm_d.push_back(w[n_im + j]);
    end
    wr0 = wr_cnt;
    pulse_start();
    chk("start_core_reset", 32'(core_reset), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_meminit", 32'(mem_init), 32'd1);
    send_word(32'(n_im), rnd);
    if (n_im > IMW) begin
      check_err();
      repeat (4) @(negedge clk);
      chk("err_no_writes", 32'(wr_cnt), 32'(wr0));
      return;
    end
    for (int i = 0; i < n_im; i++) begin
      send_word(w[i], rnd);
      if (i == glitch) ignored_start();
    end
    send_word(32'(n_dm), rnd);
    if (n_dm > SMW) begin
      check_err();
      chk("err_dm_writes", 32'(wr_cnt), 32'(wr0 + n_im));
      return;
    end
    for (int j = 0; j < n_dm; j++) send_word(w[n_im + j], rnd);
    if (n_dm > 0) begin
      chk("last_meminit", 32'(mem_init), 32'd1);
      chk("early_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("done", 32'(done), 32'd1);
    chk("done_core_reset", 32'(core_reset), 32'd0);
    chk("done_err", 32'(err), 32'd0);
    chk("done_ready", 32'(rx_ready), 32'd0);
    chk("done_meminit", 32'(mem_init), 32'd0);
    chk("im_left", 32'(im_a.size()), 32'd0);
    chk("sm_left", 32'(sm_a.size()), 32'd0);
    chk("write_count", 32'(wr_cnt), 32'(wr0 + n_im + n_dm));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_meminit"}, 32'(mem_init), 32'd0);
    chk({tag, "_we"}, 32'({we_im, we_sm}), 32'd0);
    chk({tag, "_addr"}, 32'({wa_im, wa_sm}), 32'd0);
    chk({tag, "_data_im"}, wd_im, 32'd0);
    chk({tag, "_data_sm"}, wd_sm, 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_done_err"}, 32'({done, err}), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$], e[$];
    int wr0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    q = {32'h0000_0093, 32'h0010_0113};
    do_load(2, 0, 1'b0, -1, q);
    q = {32'h1234_5678, 32'hDEAD_BEEF};
    do_load(1, 1, 1'b0, -1, q);
    for (int t = 0; t < 6; t++)
      do_load(int'($urandom_range(0, IMW)), int'($urandom_range(0, SMW)), 1'b1, -1, e);
    do_load(IMW, SMW, 1'b1, -1, e);

    do_load(IMW + 1, 0, 1'b0, -1, e);
    do_load(2, SMW + 1, 1'b1, -1, e);

    // Abort mid-word with reset, then a clean reload must start at address 0.
    pulse_start();
    wr0 = wr_cnt;
    send_word(32'd2, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_write", 32'(wr_cnt), 32'(wr0));
    do_load(2, 1, 1'b1, -1, e);

    do_load(3, 0, 1'b0, 0, e);
    do_load(2, 2, 1'b1, 1, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
